// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit.
// Holds opcode/funct constants, ALU operation codes and the packed control
// word carried through the ID/EX, EX/MEM and MEM/WB registers.
package ctrl_pkg;

  localparam int unsigned ALU_W = 8;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  // ALU operation codes (0 is the bubble / no-op)
  localparam logic [ALU_W-1:0] ALU_NOP   = 8'd0;
  localparam logic [ALU_W-1:0] ALU_ADD   = 8'd1;
  localparam logic [ALU_W-1:0] ALU_ADDU  = 8'd2;
  localparam logic [ALU_W-1:0] ALU_SUB   = 8'd3;
  localparam logic [ALU_W-1:0] ALU_SUBU  = 8'd4;
  localparam logic [ALU_W-1:0] ALU_AND   = 8'd5;
  localparam logic [ALU_W-1:0] ALU_OR    = 8'd6;
  localparam logic [ALU_W-1:0] ALU_XOR   = 8'd7;
  localparam logic [ALU_W-1:0] ALU_NOR   = 8'd8;
  localparam logic [ALU_W-1:0] ALU_SLT   = 8'd9;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 8'd10;
  localparam logic [ALU_W-1:0] ALU_SLL   = 8'd11;
  localparam logic [ALU_W-1:0] ALU_SRL   = 8'd12;
  localparam logic [ALU_W-1:0] ALU_SRA   = 8'd13;
  localparam logic [ALU_W-1:0] ALU_LUI   = 8'd14;
  localparam logic [ALU_W-1:0] ALU_MULT  = 8'd15;
  localparam logic [ALU_W-1:0] ALU_MULTU = 8'd16;
  localparam logic [ALU_W-1:0] ALU_DIV   = 8'd17;
  localparam logic [ALU_W-1:0] ALU_DIVU  = 8'd18;
  localparam logic [ALU_W-1:0] ALU_MFHI  = 8'd19;
  localparam logic [ALU_W-1:0] ALU_MFLO  = 8'd20;

  typedef struct packed {
    logic [ALU_W-1:0] alucontrol;
    logic             alusrc;
    logic             shifti;
    logic             regdst;
    logic             mdu_start;
    logic             mdu_div;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic mem2reg;
    logic link;
  } wb_ctrl_t;

  // Full control word as loaded into ID/EX
  typedef struct packed {
    ex_ctrl_t   ex;
    mem_ctrl_t  mem;
    wb_ctrl_t   wb;
    logic [4:0] writereg;
  } ctrl_word_t;

  // Later stages keep only the sub-fields they still consume
  typedef struct packed {
    mem_ctrl_t  mem;
    wb_ctrl_t   wb;
    logic [4:0] writereg;
  } exmem_word_t;

  typedef struct packed {
    wb_ctrl_t   wb;
    logic [4:0] writereg;
  } memwb_word_t;

  // ID-only decode results
  typedef struct packed {
    logic beq;
    logic jump;
    logic jumpv;
    logic mdu_dep;
    logic uses_rs;
    logic uses_rt;
  } id_ctrl_t;

  function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (use_rs && (rs == dst)) || (use_rt && (rt == dst));
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports: op_i/funct_i/rt_i/rd_i instruction fields; word_o control word for
// ID/EX (including destination register); id_o ID-only flags (branch/jump
// kind, MDU dependency, source-register usage).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output ctrl_word_t word_o,
  output id_ctrl_t   id_o
);

  logic [4:0] dst;

  always_comb begin
    word_o = '0;
    id_o   = '0;
    dst    = '0;
    case (op_i)
      OP_SPECIAL: begin
        word_o.ex.regdst   = 1'b1;
        word_o.wb.regwrite = 1'b1;
        id_o.uses_rs       = 1'b1;
        id_o.uses_rt       = 1'b1;
        case (funct_i)
          F_SLL:  begin word_o.ex.alucontrol = ALU_SLL; word_o.ex.shifti = 1'b1; id_o.uses_rs = 1'b0; end
          F_SRL:  begin word_o.ex.alucontrol = ALU_SRL; word_o.ex.shifti = 1'b1; id_o.uses_rs = 1'b0; end
          F_SRA:  begin word_o.ex.alucontrol = ALU_SRA; word_o.ex.shifti = 1'b1; id_o.uses_rs = 1'b0; end
          F_SLLV: word_o.ex.alucontrol = ALU_SLL;
          F_SRLV: word_o.ex.alucontrol = ALU_SRL;
          F_SRAV: word_o.ex.alucontrol = ALU_SRA;
          F_ADD:  word_o.ex.alucontrol = ALU_ADD;
          F_ADDU: word_o.ex.alucontrol = ALU_ADDU;
          F_SUB:  word_o.ex.alucontrol = ALU_SUB;
          F_SUBU: word_o.ex.alucontrol = ALU_SUBU;
          F_AND:  word_o.ex.alucontrol = ALU_AND;
          F_OR:   word_o.ex.alucontrol = ALU_OR;
          F_XOR:  word_o.ex.alucontrol = ALU_XOR;
          F_NOR:  word_o.ex.alucontrol = ALU_NOR;
          F_SLT:  word_o.ex.alucontrol = ALU_SLT;
          F_SLTU: word_o.ex.alucontrol = ALU_SLTU;
          F_JR: begin
            id_o.jumpv         = 1'b1;
            id_o.uses_rt       = 1'b0;
            word_o.ex.regdst   = 1'b0;
            word_o.wb.regwrite = 1'b0;
          end
          F_JALR: begin
            id_o.jumpv     = 1'b1;
            id_o.uses_rt   = 1'b0;
            word_o.wb.link = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            word_o.ex.alucontrol = (funct_i == F_MFHI) ? ALU_MFHI : ALU_MFLO;
            id_o.uses_rs         = 1'b0;
            id_o.uses_rt         = 1'b0;
            id_o.mdu_dep         = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            case (funct_i)
              F_MULT:  word_o.ex.alucontrol = ALU_MULT;
              F_MULTU: word_o.ex.alucontrol = ALU_MULTU;
              F_DIV:   word_o.ex.alucontrol = ALU_DIV;
              default: word_o.ex.alucontrol = ALU_DIVU;
            endcase
            word_o.ex.regdst    = 1'b0;
            word_o.wb.regwrite  = 1'b0;
            word_o.ex.mdu_start = 1'b1;
            word_o.ex.mdu_div   = (funct_i == F_DIV) || (funct_i == F_DIVU);
            id_o.mdu_dep        = 1'b1;
          end
          default: begin
            word_o = '0;
            id_o   = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        case (op_i)
          OP_ADDI:  word_o.ex.alucontrol = ALU_ADD;
          OP_ADDIU: word_o.ex.alucontrol = ALU_ADDU;
          OP_SLTI:  word_o.ex.alucontrol = ALU_SLT;
          OP_SLTIU: word_o.ex.alucontrol = ALU_SLTU;
          OP_ANDI:  word_o.ex.alucontrol = ALU_AND;
          OP_ORI:   word_o.ex.alucontrol = ALU_OR;
          OP_XORI:  word_o.ex.alucontrol = ALU_XOR;
          default:  word_o.ex.alucontrol = ALU_LUI;
        endcase
        word_o.ex.alusrc   = 1'b1;
        word_o.wb.regwrite = 1'b1;
        id_o.uses_rs       = (op_i != OP_LUI);
      end
      OP_LW: begin
        word_o.ex.alucontrol = ALU_ADD;
        word_o.ex.alusrc     = 1'b1;
        word_o.mem.memread   = 1'b1;
        word_o.wb.regwrite   = 1'b1;
        word_o.wb.mem2reg    = 1'b1;
        id_o.uses_rs         = 1'b1;
      end
      OP_SW: begin
        word_o.ex.alucontrol = ALU_ADD;
        word_o.ex.alusrc     = 1'b1;
        word_o.mem.memwrite  = 1'b1;
        id_o.uses_rs         = 1'b1;
        id_o.uses_rt         = 1'b1;
      end
      OP_BEQ: begin
        id_o.beq     = 1'b1;
        id_o.uses_rs = 1'b1;
        id_o.uses_rt = 1'b1;
      end
      OP_J:   id_o.jump = 1'b1;
      OP_JAL: begin
        id_o.jump          = 1'b1;
        word_o.wb.link     = 1'b1;
        word_o.wb.regwrite = 1'b1;
      end
      default: begin
        word_o = '0;
        id_o   = '0;
      end
    endcase

    // JAL links to $31; JALR links to rd like other R-type writes
    if (word_o.wb.link && !word_o.ex.regdst) dst = 5'd31;
    else if (word_o.ex.regdst)               dst = rd_i;
    else                                     dst = rt_i;

    if (dst == '0) word_o.wb.regwrite = 1'b0;
    word_o.writereg = word_o.wb.regwrite ? dst : '0;
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit.
// Decodes the ID instruction, carries control through ID/EX, EX/MEM and
// MEM/WB, detects load-use, branch-operand and MDU hazards, and drives the
// PC/IF-ID stall and flush lines.
// Ports: clk/rst (sync, active high); inst_d, branch_eq_d from ID;
// stall_f/stall_d/flush_f front-end control; jump_d/jumpv_d/beq_d decoded
// transfers; *_e EX controls; mdu_start_e/mdu_busy MDU tracking;
// writereg_{e,m,w} destinations; *_m MEM controls; *_w WB controls.
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W  = 8,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst_d,
  input  logic                 branch_eq_d,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_f,
  output logic                 jump_d,
  output logic                 jumpv_d,
  output logic                 beq_d,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic                 alusrc_e,
  output logic                 shifti_e,
  output logic                 regdst_e,
  output logic                 mdu_start_e,
  output logic                 mdu_busy,
  output logic [4:0]           writereg_e,
  output logic [4:0]           writereg_m,
  output logic [4:0]           writereg_w,
  output logic                 memread_m,
  output logic                 memwrite_m,
  output logic                 regwrite_w,
  output logic                 mem2reg_w,
  output logic                 link_w
);

  localparam int unsigned MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  ctrl_word_t  dec_word;
  id_ctrl_t    dec_id;
  ctrl_word_t  idex_q, idex_d;
  exmem_word_t exmem_q, exmem_d;
  memwb_word_t memwb_q, memwb_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic [4:0] id_rs, id_rt;
  logic       load_use, branch_haz, mdu_haz, stall;
  logic       unused_shamt;

  assign id_rs        = inst_d[25:21];
  assign id_rt        = inst_d[20:16];
  assign unused_shamt = ^inst_d[10:6];

  ctrl_decode u_decode (
    .op_i    (inst_d[31:26]),
    .funct_i (inst_d[5:0]),
    .rt_i    (id_rt),
    .rd_i    (inst_d[15:11]),
    .word_o  (dec_word),
    .id_o    (dec_id)
  );

  assign mdu_start_e = idex_q.ex.mdu_start;
  assign mdu_busy    = (mdu_cnt_q != '0);

  assign load_use = idex_q.mem.memread && (idex_q.writereg != '0) &&
                    src_hit(idex_q.writereg, id_rs, id_rt, dec_id.uses_rs, dec_id.uses_rt);

  // Branch operands are compared in ID, so an EX producer or a load still
  // in MEM cannot be forwarded in time. $0 never creates a dependency.
  assign branch_haz = (dec_id.beq || dec_id.jumpv) &&
    ((idex_q.wb.regwrite &&
      src_hit(idex_q.writereg, id_rs, id_rt, dec_id.uses_rs, dec_id.uses_rt)) ||
     (exmem_q.mem.memread && (exmem_q.writereg != '0) &&
      src_hit(exmem_q.writereg, id_rs, id_rt, dec_id.uses_rs, dec_id.uses_rt)));

  assign mdu_haz = dec_id.mdu_dep && (mdu_busy || mdu_start_e);

  // Front-end outputs are forced low while reset is held
  assign stall   = ~rst & (load_use | branch_haz | mdu_haz);
  assign stall_f = stall;
  assign stall_d = stall;
  assign jump_d  = ~rst & dec_id.jump;
  assign jumpv_d = ~rst & dec_id.jumpv;
  assign beq_d   = ~rst & dec_id.beq;
  assign flush_f = ~rst & ~stall & (dec_id.jump | dec_id.jumpv | (dec_id.beq & branch_eq_d));

  always_comb begin
    idex_d           = stall ? '0 : dec_word;
    exmem_d.mem      = idex_q.mem;
    exmem_d.wb       = idex_q.wb;
    exmem_d.writereg = idex_q.writereg;
    memwb_d.wb       = exmem_q.wb;
    memwb_d.writereg = exmem_q.writereg;

    mdu_cnt_d = mdu_cnt_q;
    if (idex_q.ex.mdu_start)    mdu_cnt_d = idex_q.ex.mdu_div ? DIV_LOAD : MUL_LOAD;
    else if (mdu_cnt_q != '0)   mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      mdu_cnt_q <= '0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign alucontrol_e = ALUCTRL_W'(idex_q.ex.alucontrol);
  assign alusrc_e     = idex_q.ex.alusrc;
  assign shifti_e     = idex_q.ex.shifti;
  assign regdst_e     = idex_q.ex.regdst;
  assign writereg_e   = idex_q.writereg;
  assign writereg_m   = exmem_q.writereg;
  assign memread_m    = exmem_q.mem.memread;
  assign memwrite_m   = exmem_q.mem.memwrite;
  assign writereg_w   = memwb_q.writereg;
  assign regwrite_w   = memwb_q.wb.regwrite;
  assign mem2reg_w    = memwb_q.wb.mem2reg;
  assign link_w       = memwb_q.wb.link;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed testbench for pipe_controller: instruction sequences driven into
// ID with hand-computed per-cycle expectations.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_d = '0;
  logic        branch_eq_d = 1'b0;
  logic        stall_f, stall_d, flush_f, jump_d, jumpv_d, beq_d;
  logic [7:0]  alucontrol_e;
  logic        alusrc_e, shifti_e, regdst_e, mdu_start_e, mdu_busy;
  logic [4:0]  writereg_e, writereg_m, writereg_w;
  logic        memread_m, memwrite_m, regwrite_w, mem2reg_w, link_w;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_controller #(.ALUCTRL_W(8), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .inst_d(inst_d), .branch_eq_d(branch_eq_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_f(flush_f),
    .jump_d(jump_d), .jumpv_d(jumpv_d), .beq_d(beq_d),
    .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e), .shifti_e(shifti_e),
    .regdst_e(regdst_e), .mdu_start_e(mdu_start_e), .mdu_busy(mdu_busy),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .memread_m(memread_m), .memwrite_m(memwrite_m), .regwrite_w(regwrite_w),
    .mem2reg_w(mem2reg_w), .link_w(link_w)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({stall_f, stall_d, flush_f, jump_d, jumpv_d, beq_d, alucontrol_e,
                alusrc_e, shifti_e, regdst_e, mdu_start_e, mdu_busy, writereg_e,
                writereg_m, writereg_w, memread_m, memwrite_m, regwrite_w,
                mem2reg_w, link_w});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge
  task automatic step(input logic [31:0] inst, input logic eq, input logic r);
    @(posedge clk);
    #1;
    inst_d      = inst;
    branch_eq_d = eq;
    rst         = r;
    @(negedge clk);
  endtask

  task automatic id(input logic [31:0] inst);
    step(inst, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) id(32'h0);
  endtask

  // Issue an MDU op, hold its dependent in ID and measure the stall window
  task automatic mdu_run(input string tag, input logic [31:0] op_inst,
                         input logic [31:0] dep_inst, input int unsigned exp_stall);
    int unsigned n_stall, n_busy, n_start, guard;
    n_stall = 0; n_busy = 0; n_start = 0; guard = 0;
    id(op_inst);
    check({tag, "_issue_stall"}, stall_d, 0);
    id(dep_inst);
    while (stall_d === 1'b1 && guard < 100) begin
      n_stall++;
      if (mdu_busy)    n_busy++;
      if (mdu_start_e) n_start++;
      guard++;
      id(dep_inst);
    end
    check({tag, "_stall_cycles"}, n_stall, exp_stall);
    check({tag, "_busy_cycles"}, n_busy, exp_stall - 1);
    check({tag, "_start_cycles"}, n_start, 1);
    check({tag, "_busy_after"}, mdu_busy, 0);
    id(32'h0);
    check({tag, "_dep_in_ex"}, writereg_e, 3);
  endtask

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with a JAL in ID: every output held low
    step({6'h03, 26'h10}, 1'b1, 1'b1);
    step({6'h03, 26'h10}, 1'b1, 1'b1);
    check("reset_outs", outs(), 0);
    id(NOP);
    check("post_reset_outs", outs(), 0);

    // Load-use: lw $2,0($1); add $3,$2,$4
    id(itype(6'h23, 5'd1, 5'd2, 16'd0));
    check("lu_first_stall", stall_d, 0);
    id(rtype(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    check("lu_stall", stall_d, 1);
    check("lu_stall_f", stall_f, 1);
    check("lu_lw_e", writereg_e, 2);
    check("lu_lw_alusrc", alusrc_e, 1);
    id(rtype(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    check("lu_release", stall_d, 0);
    check("lu_bubble_e", writereg_e, 0);
    check("lu_memread_m", memread_m, 1);
    check("lu_writereg_m", writereg_m, 2);
    id(NOP);
    check("lu_add_e", writereg_e, 3);
    check("lu_add_regdst", regdst_e, 1);
    check("lu_add_alu", alucontrol_e, 1);
    check("lu_lw_wb", {regwrite_w, mem2reg_w, writereg_w}, {2'b11, 5'd2});
    id(NOP);
    check("lu_bubble_w", regwrite_w, 0);
    id(NOP);
    check("lu_add_wb", {regwrite_w, mem2reg_w, writereg_w}, {2'b10, 5'd3});
    drain();

    // ALU producer then taken BEQ: one stall, then flush
    id(rtype(5'd1, 5'd1, 5'd5, 5'd0, 6'h20));
    check("br_add_stall", stall_d, 0);
    step(itype(6'h04, 5'd5, 5'd0, 16'd4), 1'b1, 1'b0);
    check("br_stall", stall_d, 1);
    check("br_stall_noflush", flush_f, 0);
    check("br_beq_d", beq_d, 1);
    step(itype(6'h04, 5'd5, 5'd0, 16'd4), 1'b1, 1'b0);
    check("br_release", stall_d, 0);
    check("br_flush", flush_f, 1);
    id(NOP);
    check("br_flush_drop", flush_f, 0);
    drain();

    // Load then BEQ: two stalls; not-taken BEQ never flushes
    id(itype(6'h23, 5'd1, 5'd6, 16'd4));
    step(itype(6'h04, 5'd0, 5'd6, 16'd4), 1'b1, 1'b0);
    check("lbr_stall1", stall_d, 1);
    step(itype(6'h04, 5'd0, 5'd6, 16'd4), 1'b1, 1'b0);
    check("lbr_stall2", stall_d, 1);
    step(itype(6'h04, 5'd0, 5'd6, 16'd4), 1'b1, 1'b0);
    check("lbr_release", {stall_d, flush_f}, 2'b01);
    step(itype(6'h04, 5'd0, 5'd6, 16'd4), 1'b0, 1'b0);
    check("lbr_not_taken", {beq_d, flush_f}, 2'b10);
    drain();

    // JR behind ALU producer of $31
    id(rtype(5'd1, 5'd1, 5'd31, 5'd0, 6'h20));
    id(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    check("jr_stall", {stall_d, jumpv_d, flush_f}, 3'b110);
    id(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    check("jr_flush", {stall_d, flush_f}, 2'b01);
    drain();

    // JAL: immediate flush, link write to $31 three cycles later
    id({6'h03, 26'h10});
    check("jal_jump", {jump_d, flush_f}, 2'b11);
    id(NOP);
    check("jal_e", writereg_e, 31);
    id(NOP);
    id(NOP);
    check("jal_wb", {link_w, regwrite_w, writereg_w}, {2'b11, 5'd31});
    drain();

    // Shift-immediate ignores rs; load to $0 creates no hazard or write
    id(itype(6'h23, 5'd1, 5'd7, 16'd0));
    id(rtype(5'd7, 5'd5, 5'd4, 5'd2, 6'h00));
    check("sll_rs_ignored", stall_d, 0);
    id(itype(6'h23, 5'd4, 5'd0, 16'd0));
    check("sll_shifti_e", shifti_e, 1);
    check("sll_writereg_e", writereg_e, 4);
    check("lw0_no_stall", stall_d, 0);
    id(rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'h20));
    check("lw0_use_no_stall", stall_d, 0);
    check("lw0_e", {memread_m, writereg_e}, 0);
    id(NOP);
    check("lw0_memread_m", memread_m, 1);
    id(NOP);
    check("lw0_regwrite_w", regwrite_w, 0);
    drain();

    // MDU windows
    mdu_run("div", rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1a), rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12), 32);
    drain();
    mdu_run("mult", rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h10), 4);
    drain();

    // Reset in cycle 10 of a DIV stall
    id(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h1a));
    repeat (9) id(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12));
    check("rdiv_stalling", {stall_d, mdu_busy}, 2'b11);
    step(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12), 1'b0, 1'b1);
    id(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12));
    check("rdiv_outs_zero", outs(), 0);
    check("rdiv_busy", mdu_busy, 0);
    id(NOP);
    check("rdiv_mflo_e", writereg_e, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
